div_cfg_loader: RTL

Serial configuration loader sitting directly upstream of the 4-channel clock divider/selector. It receives a 34-bit configuration word over a 3-wire serial link (cs_n/sck/sdi), synchronised into the system clock domain. It commits the word atomically to the divider's parallel configuration bus only when the frame is exactly complete. The old configuration is shifted back out on sdo during the same frame for readback.

---
 rtl/div_cfg_pkg.sv | 22 ++
 rtl/div_cfg_loader_sync.sv | 26 ++
 rtl/div_cfg_loader.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/div_cfg_pkg.sv
// Shared definitions for the divider configuration loader: word layout,
// field positions and the frame-handling state encoding.
package div_cfg_pkg;

    // Configuration word width and field layout of the divider's io_in bus
    localparam int CFG_W   = 34;
    localparam int SEL_LSB = 0;
    localparam int SEL_W   = 2;
    localparam int FA_LSB  = 2;
    localparam int FB_LSB  = 10;
    localparam int FC_LSB  = 18;
    localparam int FD_LSB  = 26;
    localparam int FACT_W  = 8;

    // Frame handling states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/div_cfg_loader_sync.sv
// N-flop synchroniser for a single asynchronous input, with a selectable
// reset value so idle levels are preserved across reset.
module cfg_sync #(
    parameter int   N       = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [N-1:0] sync_r;

    // Shift the asynchronous input through the synchroniser chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {N{RST_VAL}};
        end else begin
            sync_r <= {sync_r[N-2:0], d};
        end
    end

    assign q = sync_r[N-1];

endmodule

// File: rtl/div_cfg_loader.sv
// Serial configuration loader for the 4-channel clock divider. Receives a
// CFG_W-bit word over cs_n/sck/sdi, shifts the old word back out on sdo, and
// commits the new word atomically only when exactly CFG_W bits arrived.
module div_cfg_loader #(
    parameter int                        CFG_W       = div_cfg_pkg::CFG_W,
    parameter int                        SYNC_STAGES = 2,
    parameter logic [CFG_W-1:0]          RESET_CFG   = {CFG_W{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cs_n,
    input  logic             sck,
    input  logic             sdi,
    output logic             sdo,
    output logic [CFG_W-1:0] cfg_out,
    output logic             cfg_valid,
    output logic             frame_err
);

    import div_cfg_pkg::*;

    localparam int               CNT_W    = $clog2(CFG_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CFG_W + 1);

    logic                   cs_sync_s;
    logic                   sck_sync_s;
    logic                   sdi_sync_s;
    logic                   cs_q_r;
    logic                   sck_q_r;
    logic                   cs_fall_s;
    logic                   cs_rise_s;
    logic                   sck_rise_s;
    logic                   sck_fall_s;
    logic [SYNC_STAGES:0]   flush_r;
    logic                   armed_r;
    state_e                 state_r;
    logic [CNT_W-1:0]       bit_cnt_r;
    logic [CFG_W-1:0]       shadow_r;
    logic [CFG_W-1:0]       rd_sr_r;

    // cs_n idles high and sck idles low, so their chains reset to those levels
    cfg_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cs_n),
        .q     (cs_sync_s)
    );

    cfg_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sck),
        .q     (sck_sync_s)
    );

    cfg_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sdi (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sdi),
        .q     (sdi_sync_s)
    );

    // Delay the synchronised cs_n and sck by one cycle for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q_r  <= 1'b1;
            sck_q_r <= 1'b0;
        end else begin
            cs_q_r  <= cs_sync_s;
            sck_q_r <= sck_sync_s;
        end
    end

    assign cs_fall_s  = cs_q_r & ~cs_sync_s;
    assign cs_rise_s  = ~cs_q_r & cs_sync_s;
    assign sck_rise_s = ~sck_q_r & sck_sync_s;
    assign sck_fall_s = sck_q_r & ~sck_sync_s;

    // Track when the synchronisers have flushed their reset values, then arm
    // only once a genuinely high cs_n has been observed; a cs_n already low
    // at reset release therefore never opens a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_r <= {(SYNC_STAGES + 1){1'b0}};
            armed_r <= 1'b0;
        end else begin
            flush_r <= {flush_r[SYNC_STAGES-1:0], 1'b1};
            if (flush_r[SYNC_STAGES] && cs_sync_s) begin
                armed_r <= 1'b1;
            end else begin
                armed_r <= armed_r;
            end
        end
    end

    // Frame FSM: capture bits into the shadow, stream readback, commit on exact length
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            bit_cnt_r <= {CNT_W{1'b0}};
            shadow_r  <= {CFG_W{1'b0}};
            rd_sr_r   <= {CFG_W{1'b0}};
            cfg_out   <= RESET_CFG;
            cfg_valid <= 1'b0;
            frame_err <= 1'b0;
            sdo       <= 1'b0;
        end else begin
            cfg_valid <= 1'b0;
            frame_err <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (armed_r && cs_fall_s) begin
                        state_r   <= SHIFT;
                        bit_cnt_r <= {CNT_W{1'b0}};
                        rd_sr_r   <= cfg_out;
                        sdo       <= cfg_out[CFG_W-1];
                    end else begin
                        sdo <= 1'b0;
                    end
                end
                SHIFT: begin
                    // A cs_n rise takes priority over a coincident sck edge
                    if (cs_rise_s) begin
                        state_r <= DONE;
                        sdo     <= 1'b0;
                    end else if (sck_rise_s) begin
                        shadow_r <= {shadow_r[CFG_W-2:0], sdi_sync_s};
                        if (bit_cnt_r != CNT_MAX) begin
                            bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                        end else begin
                            bit_cnt_r <= bit_cnt_r;
                        end
                    end else if (sck_fall_s) begin
                        rd_sr_r <= {rd_sr_r[CFG_W-2:0], 1'b0};
                        sdo     <= rd_sr_r[CFG_W-2];
                    end else begin
                        sdo <= rd_sr_r[CFG_W-1];
                    end
                end
                DONE: begin
                    if (bit_cnt_r == CNT_FULL) begin
                        cfg_out   <= shadow_r;
                        cfg_valid <= 1'b1;
                    end else begin
                        frame_err <= 1'b1;
                    end
                    state_r <= IDLE;
                    sdo     <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    sdo     <= 1'b0;
                end
            endcase
        end
    end

endmodule
